// File: rtl/layer_pkg.sv
// -----------------------------------------------------------------------------
// layer_pkg
// Shared definitions for the layer MAC array:
//   - state_e     : controller states (IDLE, ACC, DRAIN, QUANT, OUT)
//   - sat_acc()   : clamp a wide signed value to the accumulator range
//   - sat_out()   : clamp a wide signed value to the result range
//   - lane_lsb()  : packing convention, lane k lives at [k*DATA_W +: DATA_W]
// All helpers work on a 64-bit signed intermediate so they are independent of
// the instance parameters; callers truncate to their own width afterwards.
// -----------------------------------------------------------------------------
package layer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC   = 3'd1,
        DRAIN = 3'd2,
        QUANT = 3'd3,
        OUT   = 3'd4
    } state_e;

    localparam int WIDE_W = 64;

    // Bit offset of lane k inside a packed vector of w-bit lanes.
    function automatic int lane_lsb(input int k, input int w);
        return k * w;
    endfunction

    // Clamp v to the signed range of a w-bit two's complement number.
    function automatic logic signed [WIDE_W-1:0] sat_to(input logic signed [WIDE_W-1:0] v,
                                                        input int w);
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = (64'sd1 <<< (w - 32'sd1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 32'sd1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

    function automatic logic signed [WIDE_W-1:0] sat_acc(input logic signed [WIDE_W-1:0] v,
                                                         input int acc_w);
        return sat_to(v, acc_w);
    endfunction

    function automatic logic signed [WIDE_W-1:0] sat_out(input logic signed [WIDE_W-1:0] v,
                                                         input int data_w);
        return sat_to(v, data_w);
    endfunction

endpackage

// File: rtl/layer_mac_lane.sv
// -----------------------------------------------------------------------------
// layer_mac_lane
// One neuron lane: product register, saturating accumulator and the
// round / arithmetic-shift / saturate requantiser.
// Optional macro LAYER_MAC_RELU_EN: clamps negative results to zero.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clr_i          clear product and accumulator (start of a computation)
//   prod_en_i      accepted beat: register x_i*w_i
//   acc_en_i       cycle after an accept: add product to accumulator
//   quant_en_i     load requantised result into res_o
//   shift_i        requantisation right shift
//   x_i, w_i       signed sample and this lane's weight
//   res_o          signed registered result
// -----------------------------------------------------------------------------
module layer_mac_lane
    import layer_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int SHIFT_W = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic                      prod_en_i,
    input  logic                      acc_en_i,
    input  logic                      quant_en_i,
    input  logic [SHIFT_W-1:0]        shift_i,
    input  logic signed [DATA_W-1:0]  x_i,
    input  logic signed [DATA_W-1:0]  w_i,
    output logic signed [DATA_W-1:0]  res_o
);

    logic signed [2*DATA_W-1:0] prod_q, prod_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [DATA_W-1:0]   res_q, res_d;

    logic signed [2*DATA_W-1:0] x_ext_s, w_ext_s;
    logic signed [WIDE_W-1:0]   sum_s, acc_sat_s, acc_wide_s;
    logic signed [WIDE_W-1:0]   rnd_s, shr_s, out_s, relu_s;
    int                         sh_s;

    // Next-state logic for product, accumulator and requantised result.
    always_comb begin
        x_ext_s = {{DATA_W{x_i[DATA_W-1]}}, x_i};
        w_ext_s = {{DATA_W{w_i[DATA_W-1]}}, w_i};

        if (clr_i) begin
            prod_d = '0;
        end else if (prod_en_i) begin
            prod_d = x_ext_s * w_ext_s;
        end else begin
            prod_d = prod_q;
        end

        // The product is consumed exactly once: acc_en_i is the delayed accept.
        sum_s     = {{(WIDE_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
                  + {{(WIDE_W-2*DATA_W){prod_q[2*DATA_W-1]}}, prod_q};
        acc_sat_s = sat_acc(sum_s, ACC_W);
        if (clr_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = acc_sat_s[ACC_W-1:0];
        end else begin
            acc_d = acc_q;
        end

        // Round half up, then arithmetic shift, then clamp to the result range.
        sh_s       = int'(shift_i);
        acc_wide_s = {{(WIDE_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        if (sh_s > 32'sd0) begin
            rnd_s = sat_acc(acc_wide_s + (64'sd1 <<< (sh_s - 32'sd1)), ACC_W);
        end else begin
            rnd_s = acc_wide_s;
        end
        shr_s = rnd_s >>> sh_s;
        out_s = sat_out(shr_s, DATA_W);
`ifdef LAYER_MAC_RELU_EN
        if (out_s < 64'sd0) begin
            relu_s = '0;
        end else begin
            relu_s = out_s;
        end
`else
        relu_s = out_s;
`endif
        if (quant_en_i) begin
            res_d = relu_s[DATA_W-1:0];
        end else begin
            res_d = res_q;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q <= '0;
            acc_q  <= '0;
            res_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
            res_q  <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/layer_mac_array.sv
// -----------------------------------------------------------------------------
// layer_mac_array
// N_LANES neurons computed in parallel over a streamed input vector.
// Holds the controller FSM, beat counter, latched length/shift and both
// handshakes; the arithmetic lives in layer_mac_lane.
// Optional macro LAYER_MAC_RELU_EN: ReLU on every lane result.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i, len_i, shift_i start request with vector length and shift
//   busy_o, err_o           not-idle flag, start-while-busy pulse
//   x_valid_i, x_ready_o    input beat handshake (ready only in ACC)
//   x_i, w_i                sample and packed per-lane weights
//   res_valid_o, res_ready_i result handshake
//   res_o                   packed per-lane results
// -----------------------------------------------------------------------------
module layer_mac_array
    import layer_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int ACC_W      = 24,
    parameter  int N_LANES    = 4,
    parameter  int MAX_INPUTS = 64,
    parameter  int SHIFT_W    = 5,
    localparam int CNT_W      = $clog2(MAX_INPUTS + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [CNT_W-1:0]            len_i,
    input  logic [SHIFT_W-1:0]          shift_i,
    output logic                        busy_o,
    output logic                        err_o,
    input  logic                        x_valid_i,
    output logic                        x_ready_o,
    input  logic signed [DATA_W-1:0]    x_i,
    input  logic [N_LANES*DATA_W-1:0]   w_i,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic [N_LANES*DATA_W-1:0]   res_o
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               busy_q, err_q, x_ready_q, res_valid_q;
    logic               acc_pend_q;

    logic               accept_s;
    logic               start_ok_s;
    logic [CNT_W-1:0]   len_clamp_s;

    // Handshake qualifiers and length clamp.
    always_comb begin
        accept_s   = x_valid_i & x_ready_q;
        start_ok_s = start_i & (state_q == IDLE);
        if (len_i > CNT_W'(MAX_INPUTS)) begin
            len_clamp_s = CNT_W'(MAX_INPUTS);
        end else begin
            len_clamp_s = len_i;
        end
    end

    // Controller FSM with registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            x_ready_q   <= 1'b0;
            res_valid_q <= 1'b0;
            acc_pend_q  <= 1'b0;
        end else begin
            err_q      <= start_i & (state_q != IDLE);
            acc_pend_q <= accept_s;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cnt_q   <= len_clamp_s;
                        shift_q <= shift_i;
                        busy_q  <= 1'b1;
                        if (len_clamp_s == '0) begin
                            state_q   <= DRAIN;
                            x_ready_q <= 1'b0;
                        end else begin
                            state_q   <= ACC;
                            x_ready_q <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (accept_s) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q   <= DRAIN;
                            x_ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Last product is added by the lanes during this cycle.
                    state_q <= QUANT;
                end
                QUANT: begin
                    state_q     <= OUT;
                    res_valid_q <= 1'b1;
                end
                OUT: begin
                    if (res_ready_i) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    x_ready_q   <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign x_ready_o   = x_ready_q;
    assign res_valid_o = res_valid_q;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        layer_mac_lane #(
            .DATA_W  (DATA_W),
            .ACC_W   (ACC_W),
            .SHIFT_W (SHIFT_W)
        ) u_lane (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .clr_i      (start_ok_s),
            .prod_en_i  (accept_s),
            .acc_en_i   (acc_pend_q),
            .quant_en_i (state_q == QUANT),
            .shift_i    (shift_q),
            .x_i        (x_i),
            .w_i        (w_i[lane_lsb(k, DATA_W) +: DATA_W]),
            .res_o      (res_o[lane_lsb(k, DATA_W) +: DATA_W])
        );
    end

endmodule

// File: tb/tb_layer_mac_array.sv
// -----------------------------------------------------------------------------
// tb_layer_mac_array
// Randomised and directed stimulus against a plain-arithmetic reference model
// (per-beat saturating sum, round, shift, clamp). LAYER_MAC_RELU_EN switches
// the model's ReLU as well.
// -----------------------------------------------------------------------------
module tb_layer_mac_array;

    localparam int DATA_W     = 8;
    localparam int ACC_W      = 24;
    localparam int N_LANES    = 4;
    localparam int MAX_INPUTS = 64;
    localparam int SHIFT_W    = 5;
    localparam int CNT_W      = $clog2(MAX_INPUTS + 1);

    logic                       clk_i = 1'b0;
    logic                       rst_i;
    logic                       start_i;
    logic [CNT_W-1:0]           len_i;
    logic [SHIFT_W-1:0]         shift_i;
    logic                       busy_o, err_o;
    logic                       x_valid_i, x_ready_o;
    logic signed [DATA_W-1:0]   x_i;
    logic [N_LANES*DATA_W-1:0]  w_i;
    logic                       res_valid_o, res_ready_i;
    logic [N_LANES*DATA_W-1:0]  res_o;

    layer_mac_array #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .N_LANES(N_LANES),
        .MAX_INPUTS(MAX_INPUTS), .SHIFT_W(SHIFT_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
        .shift_i(shift_i), .busy_o(busy_o), .err_o(err_o),
        .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .x_i(x_i), .w_i(w_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_o(res_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;

    int xs [MAX_INPUTS];
    int ws [MAX_INPUTS][N_LANES];
    bit gap_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_total++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint clampw(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Reference: saturating running sum, round half up, shift, clamp.
    function automatic longint model_lane(input int k, input int n, input int sh);
        longint acc = 0;
        for (int i = 0; i < n; i++) begin
            acc = clampw(acc + longint'(xs[i]) * longint'(ws[i][k]), ACC_W);
        end
        if (sh > 0) acc = clampw(acc + (longint'(1) <<< (sh - 1)), ACC_W);
        acc = acc >>> sh;
        acc = clampw(acc, DATA_W);
`ifdef LAYER_MAC_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc;
    endfunction

    function automatic longint lane_val(input int k);
        logic signed [DATA_W-1:0] v;
        v = res_o[k*DATA_W +: DATA_W];
        return longint'(v);
    endfunction

    task automatic drive_beat(input int i);
        logic [31:0] t;
        t   = xs[i];
        x_i = t[DATA_W-1:0];
        for (int k = 0; k < N_LANES; k++) begin
            t = ws[i][k];
            w_i[k*DATA_W +: DATA_W] = t[DATA_W-1:0];
        end
    endtask

    // One full computation; mode 0 = always valid, 1 = gap pattern, 2 = random.
    task automatic do_run(input string nm, input int len_req, input int sh,
                          input int mode, input int rdy_wait, input bit poke);
        int      n, beat, cyc;
        bit      acc_now;
        longint  exp_r [N_LANES];
        logic [31:0] t;
        n = (len_req > MAX_INPUTS) ? MAX_INPUTS : len_req;
        for (int k = 0; k < N_LANES; k++) exp_r[k] = model_lane(k, n, sh);

        t       = len_req;
        len_i   = t[CNT_W-1:0];
        t       = sh;
        shift_i = t[SHIFT_W-1:0];
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk({nm, ":busy"}, longint'(busy_o), 1);
        chk({nm, ":rdy_start"}, longint'(x_ready_o), (n > 0) ? 1 : 0);

        beat = 0;
        cyc  = 0;
        while (beat < n && cyc < 4 * MAX_INPUTS + 50) begin
            case (mode)
                0:       x_valid_i = 1'b1;
                1:       x_valid_i = gap_pat[cyc % 6];
                default: x_valid_i = 1'($urandom_range(0, 1));
            endcase
            if (poke && cyc == 0) start_i = 1'b1;
            drive_beat(beat);
            acc_now = x_valid_i && x_ready_o;
            @(posedge clk_i); #1;
            if (start_i) begin
                start_i = 1'b0;
                chk({nm, ":err_acc"}, longint'(err_o), 1);
            end
            if (acc_now) beat++;
            cyc++;
        end
        x_valid_i = 1'b0;
        if (beat < n) chk({nm, ":timeout_beats"}, longint'(beat), longint'(n));

        // Last accepting edge (or start edge) entered DRAIN; OUT two edges later.
        chk({nm, ":valid_e1"}, longint'(res_valid_o), 0);
        chk({nm, ":rdy_done"}, longint'(x_ready_o), 0);
        chk({nm, ":err_idle"}, longint'(err_o), 0);
        @(posedge clk_i); #1;
        chk({nm, ":valid_e2"}, longint'(res_valid_o), 0);
        @(posedge clk_i); #1;
        chk({nm, ":valid_e3"}, longint'(res_valid_o), 1);
        for (int k = 0; k < N_LANES; k++) chk($sformatf("%s:lane%0d", nm, k), lane_val(k), exp_r[k]);

        for (int c = 0; c < rdy_wait; c++) begin
            if (poke && c == 1) start_i = 1'b1;
            @(posedge clk_i); #1;
            if (start_i) begin
                start_i = 1'b0;
                chk({nm, ":err_out"}, longint'(err_o), 1);
            end
            chk({nm, ":valid_hold"}, longint'(res_valid_o), 1);
            for (int k = 0; k < N_LANES; k++) chk({nm, ":stable"}, lane_val(k), exp_r[k]);
        end

        res_ready_i = 1'b1;
        @(posedge clk_i); #1;
        res_ready_i = 1'b0;
        chk({nm, ":valid_drop"}, longint'(res_valid_o), 0);
        chk({nm, ":busy_drop"}, longint'(busy_o), 0);
        chk({nm, ":err_end"}, longint'(err_o), 0);
        chk({nm, ":res_keep"}, lane_val(0), exp_r[0]);
    endtask

    task automatic fill_const(input int n, input int xv, input int wv);
        for (int i = 0; i < n; i++) begin
            xs[i] = xv;
            for (int k = 0; k < N_LANES; k++) ws[i][k] = wv;
        end
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) begin
            xs[i] = int'($urandom_range(0, 255)) - 128;
            for (int k = 0; k < N_LANES; k++) ws[i][k] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic fill_basic();
        for (int i = 0; i < 3; i++) begin
            xs[i]    = i + 1;
            ws[i][0] = 1;
            ws[i][1] = -1;
            ws[i][2] = 2;
            ws[i][3] = 0;
        end
    endtask

    initial begin
        longint basic_exp [N_LANES];
`ifdef LAYER_MAC_RELU_EN
        basic_exp = '{6, 0, 12, 0};
`else
        basic_exp = '{6, -6, 12, 0};
`endif
        rst_i = 1'b1; start_i = 1'b0; len_i = '0; shift_i = '0;
        x_valid_i = 1'b0; x_i = '0; w_i = '0; res_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_busy", longint'(busy_o), 0);
        chk("rst_ready", longint'(x_ready_o), 0);
        chk("rst_valid", longint'(res_valid_o), 0);
        chk("rst_res", longint'(res_o), 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Basic dot product.
        fill_basic();
        do_run("basic", 3, 0, 0, 0, 1'b0);
        for (int k = 0; k < N_LANES; k++) chk($sformatf("basic_const%0d", k), lane_val(k), basic_exp[k]);

        // Backpressure on both sides plus protocol errors in ACC and OUT.
        do_run("bp", 3, 0, 1, 5, 1'b1);
        for (int k = 0; k < N_LANES; k++) chk($sformatf("bp_const%0d", k), lane_val(k), basic_exp[k]);

        // Rounding with large products: 4*127*127 = 64516 -> 126.
        fill_const(4, 127, 127);
        do_run("round", 4, 9, 0, 1, 1'b0);
        chk("round_const", lane_val(2), 126);

        // Zero length.
        do_run("zero", 0, 3, 0, 0, 1'b0);
        chk("zero_const", lane_val(3), 0);

        // Over-length request clamps to MAX_INPUTS; extreme negative data.
        fill_const(MAX_INPUTS, -128, -128);
        ws[5][1] = 127;
        do_run("clamp", 100, 12, 0, 0, 1'b0);

        // Randomised runs.
        for (int r = 0; r < 6; r++) begin
            int n, sh, rw;
            n  = int'($urandom_range(1, 24));
            sh = int'($urandom_range(0, 15));
            rw = int'($urandom_range(0, 3));
            fill_rand(n);
            do_run($sformatf("rnd%0d", r), n, sh, 2, rw, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of ACC after 2 of 5 beats.
        fill_const(5, 3, 3);
        len_i = CNT_W'(5); shift_i = '0; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        x_valid_i = 1'b1;
        drive_beat(0);
        repeat (2) begin
            @(posedge clk_i); #1;
        end
        x_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk("mid_rst_busy", longint'(busy_o), 0);
        chk("mid_rst_ready", longint'(x_ready_o), 0);
        chk("mid_rst_valid", longint'(res_valid_o), 0);
        chk("mid_rst_err", longint'(err_o), 0);
        chk("mid_rst_res", longint'(res_o), 0);
        #1 rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("post_rst_idle", longint'(res_valid_o), 0);

        xs[0] = 4; xs[1] = 5;
        for (int i = 0; i < 2; i++) for (int k = 0; k < N_LANES; k++) ws[i][k] = 1;
        do_run("after_rst", 2, 0, 0, 0, 1'b0);
        for (int k = 0; k < N_LANES; k++) chk($sformatf("after_rst_const%0d", k), lane_val(k), 9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
